tx_rr_arbiter: RTL



---
 rtl/tx_rr_arbiter_if.sv | 33 +++
 rtl/tx_rr_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/tx_rr_arbiter_if.sv
// Handshake bundle between the requesters, the tx_rr_arbiter and its downstream consumer.
// With TX_ARB_LOCK_EN defined, the bundle also carries the per-requester lock request req_lock_i.
interface tx_rr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 4
);
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic                    valid_o;
  logic [DATA_W-1:0]       data_o;
  logic                    ready_i;
  logic [N_REQ-1:0]        grant_o;
`ifdef TX_ARB_LOCK_EN
  logic [N_REQ-1:0]        req_lock_i;
`endif

  modport master (
`ifdef TX_ARB_LOCK_EN
    input  req_lock_i,
`endif
    input  req_valid_i, req_data_i, ready_i,
    output req_ready_o, valid_o, data_o, grant_o
  );

  modport slave (
`ifdef TX_ARB_LOCK_EN
    output req_lock_i,
`endif
    output req_valid_i, req_data_i, ready_i,
    input  req_ready_o, valid_o, data_o, grant_o
  );
endinterface

// File: rtl/tx_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready transmit channel among N_REQ requesters.
// Optional feature TX_ARB_LOCK_EN: a granted requester can lock the channel for consecutive words.
module tx_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  tx_rr_arbiter_if.master bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
`ifdef TX_ARB_LOCK_EN
  logic              lock_q, lock_d;
`endif

  logic [DATA_W-1:0] req_word [N_REQ];
  logic              load;
  logic              any_valid;
  logic              rr_found;
  logic [PTR_W-1:0]  rr_idx;
  logic [PTR_W-1:0]  win_idx;
  logic [N_REQ-1:0]  win_onehot;
  logic [PTR_W-1:0]  cand_idx;
  int                cand;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_word[gi] = bus.req_data_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = rr_ptr_q;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand     = (32'(rr_ptr_q) + i) % N_REQ;
      cand_idx = PTR_W'(cand);
      if (!rr_found && bus.req_valid_i[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    any_valid = |bus.req_valid_i;
    load      = (state_q == IDLE) || bus.ready_i;
    win_idx   = rr_idx;
`ifdef TX_ARB_LOCK_EN
    // While locked, rr_ptr_q still names the locking requester.
    if (lock_q && bus.req_valid_i[rr_ptr_q]) begin
      win_idx = rr_ptr_q;
    end
`endif
    win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
  end

  // Next-state process
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
`ifdef TX_ARB_LOCK_EN
    lock_d   = lock_q;
`endif
    if (load) begin
      if (any_valid) begin
        state_d  = SEND;
        data_d   = req_word[win_idx];
        grant_d  = win_onehot;
        rr_ptr_d = win_idx;
`ifdef TX_ARB_LOCK_EN
        lock_d   = bus.req_lock_i[win_idx];
`endif
      end else begin
        state_d = IDLE;
        grant_d = '0;
`ifdef TX_ARB_LOCK_EN
        lock_d  = 1'b0;
`endif
      end
    end
  end

  // State register process
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      grant_q  <= '0;
      rr_ptr_q <= PTR_W'(N_REQ - 1);
`ifdef TX_ARB_LOCK_EN
      lock_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef TX_ARB_LOCK_EN
      lock_q   <= lock_d;
`endif
    end
  end

  // Output process
  always_comb begin
    bus.valid_o     = (state_q == SEND);
    bus.data_o      = data_q;
    bus.grant_o     = grant_q;
    bus.req_ready_o = (load && any_valid && !rst) ? win_onehot : '0;
  end
endmodule
